// File: rtl/mux_nto1_stream.sv
// rtl/mux_nto1_stream.sv - N-input valid/ready stream mux with one registered output stage
// Grant comes from i_sel (MODE 0) or a round-robin search after the last served channel (MODE 1).
module mux_nto1_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SELW = $clog2(N)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [SELW-1:0]    i_sel,
  input  logic [N*WIDTH-1:0] i_in_data,
  input  logic [N-1:0]       i_in_valid,
  output logic [N-1:0]       o_in_ready,
  output logic [WIDTH-1:0]   o_out_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [SELW-1:0]    o_out_src
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [SELW-1:0]  r_src;

  logic             w_can_load;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_gnt_idx;
  logic [WIDTH-1:0] w_gnt_data;
  logic             w_gnt_in_valid;
  logic             w_accept;

  assign w_can_load = !r_valid || i_out_ready;

  generate
    if (MODE == 0) begin : g_sel
      always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        if ({1'b0, i_sel} < (SELW+1)'(N)) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = i_sel;
        end
      end
    end else begin : g_rr
      logic [SELW-1:0] r_ptr;
      logic            w_unused_sel;
      assign w_unused_sel = ^i_sel;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)      r_ptr <= SELW'(N-1);
        else if (w_accept) r_ptr <= w_gnt_idx;
      end

      // Channels after r_ptr outrank the wrapped ones; within each region the lowest index wins.
      always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = N-1; i >= 0; i--) begin
          if (i_in_valid[i] && (SELW'(i) <= r_ptr)) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = SELW'(i);
          end
        end
        for (int i = N-1; i >= 0; i--) begin
          if (i_in_valid[i] && (SELW'(i) > r_ptr)) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = SELW'(i);
          end
        end
      end
    end
  endgenerate

  always_comb begin
    w_gnt_data     = '0;
    w_gnt_in_valid = 1'b0;
    o_in_ready     = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt_vld && (w_gnt_idx == SELW'(i))) begin
        w_gnt_data     = i_in_data[i*WIDTH +: WIDTH];
        w_gnt_in_valid = i_in_valid[i];
        o_in_ready[i]  = w_can_load;
      end
    end
  end

  assign w_accept = w_can_load && w_gnt_in_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_gnt_data;
      r_src   <= w_gnt_idx;
    end else if (i_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_out_data  = r_data;
  assign o_out_valid = r_valid;
  assign o_out_src   = r_src;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// tb/tb_mux_nto1_stream.sv - scoreboard bench: select mux N=4, round-robin N=4, select mux N=3
module tb_mux_nto1_stream;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  sel  [3];
  logic [31:0] din  [3];
  logic [3:0]  vin  [3];
  logic        ordy [3];

  logic [3:0] rdy0, rdy1;
  logic [2:0] rdy2;
  logic [7:0] dout0, dout1, dout2;
  logic       ov0, ov1, ov2;
  logic [1:0] src0, src1, src2;

  logic [3:0] rdy  [3];
  logic [7:0] dout [3];
  logic       ov   [3];
  logic [1:0] src  [3];
  assign rdy[0] = rdy0;  assign rdy[1] = rdy1;  assign rdy[2] = {1'b0, rdy2};
  assign dout[0] = dout0; assign dout[1] = dout1; assign dout[2] = dout2;
  assign ov[0] = ov0;    assign ov[1] = ov1;    assign ov[2] = ov2;
  assign src[0] = src0;  assign src[1] = src1;  assign src[2] = src2;

  mux_nto1_stream #(.WIDTH(8), .N(4), .MODE(0)) u_sel4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel[0]), .i_in_data(din[0]), .i_in_valid(vin[0]),
    .o_in_ready(rdy0), .o_out_data(dout0), .o_out_valid(ov0), .i_out_ready(ordy[0]), .o_out_src(src0));

  mux_nto1_stream #(.WIDTH(8), .N(4), .MODE(1)) u_rr4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel[1]), .i_in_data(din[1]), .i_in_valid(vin[1]),
    .o_in_ready(rdy1), .o_out_data(dout1), .o_out_valid(ov1), .i_out_ready(ordy[1]), .o_out_src(src1));

  mux_nto1_stream #(.WIDTH(8), .N(3), .MODE(0)) u_sel3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_sel(sel[2]), .i_in_data(din[2][23:0]), .i_in_valid(vin[2][2:0]),
    .o_in_ready(rdy2), .o_out_data(dout2), .o_out_valid(ov2), .i_out_ready(ordy[2]), .o_out_src(src2));

  // Reference model state: occupancy of the output stage and round-robin last-served channel.
  logic       m_full  [3];
  int         m_ptr   [3];
  logic [3:0] exp_rdy [3];
  logic       exp_ov  [3];
  logic [9:0] q0[$], q1[$], q2[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       done = 1'b0;

  function automatic int chan_count(int d);
    return (d == 2) ? 3 : 4;
  endfunction

  function automatic int grant(int d, int ptr);
    int n = chan_count(d);
    if (d != 1) return (int'(sel[d]) < n) ? int'(sel[d]) : -1;
    for (int k = 1; k <= n; k++)
      if (vin[d][(ptr + k) % n]) return (ptr + k) % n;
    return -1;
  endfunction

  task automatic model_clear(int d);
    m_full[d] = 1'b0;
    m_ptr[d]  = chan_count(d) - 1;
    exp_ov[d] = 1'b0;
    exp_rdy[d] = 4'b0;
    if (d == 0) q0.delete(); else if (d == 1) q1.delete(); else q2.delete();
  endtask

  task automatic push(int d, logic [9:0] w);
    if (d == 0) q0.push_back(w); else if (d == 1) q1.push_back(w); else q2.push_back(w);
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic step();
    logic nx_full [3];
    int   nx_ptr  [3];
    for (int d = 0; d < 3; d++) begin
      int   g;
      logic can, acc;
      can = !m_full[d] || ordy[d];
      g   = grant(d, m_ptr[d]);
      exp_ov[d]  = m_full[d];
      exp_rdy[d] = (can && g >= 0) ? 4'(1 << g) : 4'b0;
      acc = 1'b0;
      if (rst_n && can && g >= 0) acc = vin[d][g];
      if (acc) push(d, {2'(g), din[d][g*8 +: 8]});
      nx_full[d] = acc ? 1'b1 : ((m_full[d] && ordy[d]) ? 1'b0 : m_full[d]);
      nx_ptr[d]  = acc ? g : m_ptr[d];
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        m_full[d] = 1'b0;
        m_ptr[d]  = chan_count(d) - 1;
      end else begin
        m_full[d] = nx_full[d];
        m_ptr[d]  = nx_ptr[d];
      end
    end
    #1;
  endtask

  task automatic check(string nm, int d, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d t=%0t: got %h expected %h", nm, d, $time, act, exp);
    end
  endtask

  task automatic pop_check(int d);
    int         sz;
    logic [9:0] e;
    sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL out_word dut%0d t=%0t: got %h expected no word", d, $time, {src[d], dout[d]});
    end else begin
      if (d == 0) e = q0.pop_front(); else if (d == 1) e = q1.pop_front(); else e = q2.pop_front();
      check("out_word", d, {22'b0, src[d], dout[d]}, {22'b0, e});
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        check("rst_valid", d, 32'(ov[d]), 32'd0);
        check("rst_data",  d, 32'(dout[d]), 32'd0);
        check("rst_src",   d, 32'(src[d]), 32'd0);
      end else begin
        check("in_ready",  d, 32'(rdy[d]), 32'(exp_rdy[d]));
        check("ready_1hot", d, 32'($countones(rdy[d]) <= 1), 32'd1);
        check("out_valid", d, 32'(ov[d]), 32'(exp_ov[d]));
        if (ov[d] && ordy[d]) pop_check(d);
      end
    end
    if (done) begin
      check("q_empty", 0, q0.size(), 0);
      check("q_empty", 1, q1.size(), 0);
      check("q_empty", 2, q2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
    end
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      sel[d] = '0; din[d] = '0; vin[d] = '0; ordy[d] = 1'b0;
      model_clear(d);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int c = 0; c < 6; c++) begin
      sel[0] = 2'(c % 4); din[0] = 32'h44332211; vin[0] = 4'hF; ordy[0] = 1'b1;
      sel[1] = 2'(c);     din[1] = $urandom;     vin[1] = 4'hF; ordy[1] = 1'b1;
      sel[2] = 2'(c % 4); din[2] = 32'h00332211; vin[2] = 4'h7; ordy[2] = 1'b1;
      step();
    end

    for (int c = 0; c < 8; c++) begin
      ordy[0] = !(c >= 1 && c <= 3);
      vin[0]  = (c >= 5) ? 4'h0 : 4'hF;
      if (c == 0)      begin sel[0] = 2'd1; din[0] = 32'h0000A500; end
      else if (c == 4) begin sel[0] = 2'd2; din[0] = 32'h005A0000; end
      else             begin sel[0] = 2'($urandom); din[0] = $urandom; end
      vin[1] = 4'b1010; ordy[1] = (c % 2 == 0); din[1] = $urandom;
      sel[2] = 2'($urandom); vin[2] = 4'($urandom); ordy[2] = 1'($urandom); din[2] = $urandom;
      step();
    end

    for (int d = 0; d < 3; d++) begin
      sel[d] = 2'd1; vin[d] = 4'hF; ordy[d] = 1'b1; din[d] = $urandom;
    end
    step();
    for (int d = 0; d < 3; d++) begin
      ordy[d] = 1'b0;
      model_clear(d);
    end
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    for (int c = 0; c < 300; c++) begin
      for (int d = 0; d < 3; d++) begin
        sel[d]  = 2'($urandom_range(0, 3));
        din[d]  = $urandom;
        vin[d]  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom);
        ordy[d] = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    for (int d = 0; d < 3; d++) begin
      vin[d] = 4'h0; ordy[d] = 1'b1;
    end
    repeat (3) step();
    done = 1'b1;
    repeat (4) @(posedge clk);
    $display("FAIL summary_timeout: monitor never reached the summary");
    $fatal(1);
  end

endmodule
